ef_i2c_line_conditioner: RTL and testbench
==========================================

// Module: ef_i2c_line_conditioner
// PURPOSE
//  Pad-side stage between the I2C pads and the i2c master core/APB wrapper.
//  Synchronises and deglitches raw SCL/SDA into scl_i/sda_i for the controller,
//  converts controller drive (x_o, x_oen_o) to open-drain pad enables, and
//  reports START/STOP/bus-busy status (plus optional SCL-low timeout) for IRQ logic.
// PARAMETERS
//  SYNC_STAGES     2     synchroniser depth per line; legal >= 2
//  FILTER_LEN      4     consecutive stable cycles required to accept a level; 0 = bypass
//  TIMEOUT_CYCLES  10000 SCL-low cycles (bus busy) before scl_timeout; used only with macro
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous reset, active high
//  scl_pad_i      in   1  raw SCL from pad
//  sda_pad_i      in   1  raw SDA from pad
//  scl_o          in   1  controller SCL drive value
//  scl_oen_o      in   1  controller SCL output enable, 1 = released
//  sda_o          in   1  controller SDA drive value
//  sda_oen_o      in   1  controller SDA output enable, 1 = released
//  scl_i          out  1  filtered SCL to controller
//  sda_i          out  1  filtered SDA to controller
//  scl_pad_oen_o  out  1  pad enable, 1 = high-Z (pad data tied 0 externally)
//  sda_pad_oen_o  out  1  pad enable, 1 = high-Z
//  start_det      out  1  1-cycle pulse: START/repeated START seen
//  stop_det       out  1  1-cycle pulse: STOP seen
//  bus_busy       out  1  level: bus between START and STOP
//  scl_timeout    out  1  1-cycle pulse: SCL held low too long
// BEHAVIOUR
//  Reset (sync, next edge, also mid-operation): sync chains and filtered lines = 1,
//   filter counters = 0, start_det/stop_det/scl_timeout = 0, bus_busy = 0, FSM = IDLE.
//  Pad drive (combinational, no reset dependency): x_pad_oen_o = x_oen_o | x_o.
//   Lines are never driven high.
//  Sync: raw pad shifts through SYNC_STAGES flops; synced value valid on edge SYNC_STAGES.
//  Filter (per line): cnt width $clog2(FILTER_LEN+1).
//   synced == filtered -> cnt <= 0.
//   synced != filtered, cnt < FILTER_LEN-1 -> cnt <= cnt+1.
//   synced != filtered, cnt == FILTER_LEN-1 -> filtered <= synced, cnt <= 0.
//   => pulses shorter than FILTER_LEN cycles are rejected; accepted edge latency =
//      SYNC_STAGES+FILTER_LEN edges. FILTER_LEN = 0: filtered = synced, no counter.
//  scl_i/sda_i = filtered values (registered).
//  Detection uses filtered values and one-cycle-delayed copies (scl_d, sda_d):
//   START = scl_d & scl_i & sda_d & ~sda_i;  STOP = scl_d & scl_i & ~sda_d & sda_i.
//   SDA change in the same cycle SCL changes -> neither event.
//   start_det/stop_det registered: pulse on the edge after the condition, 1 cycle wide.
//  FSM (bus_busy = state==BUSY):
//   IDLE -> BUSY on START; BUSY -> BUSY on START (repeated START, start_det pulses);
//   BUSY -> IDLE on STOP or timeout; STOP in IDLE -> stop_det pulses, stays IDLE.
//   bus_busy changes on the same edge as the corresponding pulse.
//  Timeout and STOP on same edge: both pulses assert, state -> IDLE.
// CONFIGURATION
//  EF_I2C_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYCLES+1)) increments
//   each cycle scl_i==0 and bus_busy; clears when scl_i==1 or IDLE. On reaching
//   TIMEOUT_CYCLES: scl_timeout pulses 1 cycle, FSM -> IDLE, counter saturates
//   (no repeat pulse) until scl_i returns high.
//  Not defined: no counter logic; scl_timeout tied 0; TIMEOUT_CYCLES ignored.
// TESTING (SYNC_STAGES=2, FILTER_LEN=4)
//  Reset 3 cycles, pads=1, controller released -> scl_i=sda_i=1, bus_busy=0,
//   pulses 0, both pad_oen=1. Repeat with pads=0 -> filtered still 1 during reset.
//  sda_pad_i low 3 cycles -> sda_i stays 1. Low 10 cycles -> sda_i falls on edge 6
//   after first low sample, rises 6 edges after pad returns high.
//  scl_pad_i=1, sda_pad_i 1->0 -> start_det one pulse, bus_busy=1 same edge;
//   then sda 0->1 with scl=1 -> stop_det one pulse, bus_busy=0.
//  scl and sda fall on same cycle -> no start_det; sda toggles while scl=0 -> no pulses.
//  scl_o=1,scl_oen_o=0 -> scl_pad_oen_o=1; scl_o=0,scl_oen_o=0 -> 0; scl_oen_o=1 -> 1.
//  EF_I2C_TIMEOUT_EN, TIMEOUT_CYCLES=100: START then scl held low 200 cycles ->
//   exactly one scl_timeout pulse, bus_busy=0; without macro -> scl_timeout stays 0.

Source files
------------

// File: rtl/ef_i2c_line_conditioner.sv
// Purpose: pad-side I2C conditioning - sync/deglitch SCL/SDA, open-drain enables, START/STOP/busy status.
// Latency: filtered lines lag pads by SYNC_STAGES+FILTER_LEN edges; status pulses one edge after that.
// Backpressure: none, free-running on every clock; optional SCL-low timeout under `EF_I2C_TIMEOUT_EN.
module ef_i2c_line_conditioner #(
    parameter int SYNC_STAGES    = 2,     // must be >= 2
    parameter int FILTER_LEN     = 4,     // 0 bypasses the glitch filter
    parameter int TIMEOUT_CYCLES = 10000  // only meaningful with EF_I2C_TIMEOUT_EN
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    input  logic scl_o,
    input  logic scl_oen_o,
    input  logic sda_o,
    input  logic sda_oen_o,
    output logic scl_i,
    output logic sda_i,
    output logic scl_pad_oen_o,
    output logic sda_pad_oen_o,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic scl_timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CW = (FILTER_LEN > 0) ? $clog2(FILTER_LEN + 1) : 1;

    // Index 0 = SCL, index 1 = SDA throughout.
    logic [1:0] pad_raw;
    logic [1:0] synced;
    logic [1:0] filt;
    logic [1:0] dly_q;

    logic   start_c, stop_c, timeout_c;
    state_t state_q, state_d;
    logic   start_q, start_d, stop_q, stop_d, tout_q, tout_d;

    // Open-drain: only ever pull low, a high drive value means release.
    assign scl_pad_oen_o = scl_oen_o | scl_o;
    assign sda_pad_oen_o = sda_oen_o | sda_o;

    assign pad_raw = {sda_pad_i, scl_pad_i};

    for (genvar l = 0; l < 2; l++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q;

        // Synchroniser chain, idles high like a released bus.
        always_ff @(posedge clk) begin
            if (rst) sync_q <= '1;
            else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad_raw[l]};
        end
        assign synced[l] = sync_q[SYNC_STAGES-1];

        if (FILTER_LEN > 0) begin : g_filt
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
            logic [CW-1:0] cnt_q;
            logic          filt_q;

            // Accept a new level only after FILTER_LEN consecutive disagreeing samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else if (synced[l] == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    filt_q <= synced[l];
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            assign filt[l] = filt_q;
        end else begin : g_bypass
            assign filt[l] = synced[l];
        end
    end

    assign scl_i = filt[0];
    assign sda_i = filt[1];

    // One-cycle-old filtered copies for edge detection.
    always_ff @(posedge clk) begin
        if (rst) dly_q <= 2'b11;
        else     dly_q <= filt;
    end

    // SDA edge while SCL stays high on both samples; SCL moving kills either event.
    assign start_c = dly_q[0] & filt[0] &  dly_q[1] & ~filt[1];
    assign stop_c  = dly_q[0] & filt[0] & ~dly_q[1] &  filt[1];

`ifdef EF_I2C_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt_q, tcnt_d;

    // Count SCL-low cycles while busy; saturate so only one pulse fires per low period.
    always_comb begin
        tcnt_d    = tcnt_q;
        timeout_c = 1'b0;
        if ((state_q != BUSY) || filt[0]) begin
            tcnt_d = '0;
        end else if (tcnt_q != T_MAX) begin
            tcnt_d = tcnt_q + TW'(1);
            if (tcnt_d == T_MAX) timeout_c = 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) tcnt_q <= '0;
        else     tcnt_q <= tcnt_d;
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Bus state next-state and registered pulse values.
    always_comb begin
        state_d = state_q;
        start_d = start_c;
        stop_d  = stop_c;
        tout_d  = timeout_c;
        case (state_q)
            IDLE: if (start_c) state_d = BUSY;
            BUSY: begin
                if (start_c)                 state_d = BUSY;
                else if (stop_c | timeout_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and status pulse registers, so busy moves on the same edge as its pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            tout_q  <= tout_d;
        end
    end

    assign start_det   = start_q;
    assign stop_det    = stop_q;
    assign scl_timeout = tout_q;
    assign bus_busy    = (state_q == BUSY);

endmodule

// File: tb/tb_ef_i2c_line_conditioner.sv
// Bench for ef_i2c_line_conditioner: window-based line model plus directed pad sequences.
// Latency: model tracks the DUT cycle for cycle; outputs compared every falling edge.
// Backpressure: n/a.
module tb_ef_i2c_line_conditioner;
    localparam int SYNC = 2;
    localparam int FL   = 4;
    localparam int T    = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_pad_i = 1'b1, sda_pad_i = 1'b1;
    logic scl_o = 1'b0, scl_oen_o = 1'b1, sda_o = 1'b0, sda_oen_o = 1'b1;
    logic scl_i, sda_i, scl_pad_oen_o, sda_pad_oen_o;
    logic start_det, stop_det, bus_busy, scl_timeout;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ef_i2c_line_conditioner #(
        .SYNC_STAGES(SYNC), .FILTER_LEN(FL), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
        .scl_o(scl_o), .scl_oen_o(scl_oen_o), .sda_o(sda_o), .sda_oen_o(sda_oen_o),
        .scl_i(scl_i), .sda_i(sda_i),
        .scl_pad_oen_o(scl_pad_oen_o), .sda_pad_oen_o(sda_pad_oen_o),
        .start_det(start_det), .stop_det(stop_det),
        .bus_busy(bus_busy), .scl_timeout(scl_timeout)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pad sample history (bit 0 newest). A filtered line flips once the last FL
    // synchronised samples all disagree with it; synchronised = pad delayed SYNC edges.
    logic [15:0] h_scl, h_sda;
    logic m_scl, m_sda, m_scl_p, m_sda_p;
    logic m_busy, m_start, m_stop, m_to;
    int   lc;
    bit   started = 0;

    function automatic logic filt_next(input logic [15:0] h, input logic cur);
        logic all_diff;
        all_diff = 1'b1;
        for (int i = 0; i < FL; i++)
            if (h[SYNC-1+i] == cur) all_diff = 1'b0;
        return all_diff ? ~cur : cur;
    endfunction

    always @(posedge clk) begin
        logic ev_start, ev_stop, to_ev;
        started = 1;
        if (rst) begin
            h_scl = '1; h_sda = '1;
            m_scl = 1; m_sda = 1; m_scl_p = 1; m_sda_p = 1;
            m_busy = 0; m_start = 0; m_stop = 0; m_to = 0; lc = 0;
        end else begin
            ev_start = m_scl_p & m_scl & m_sda_p & ~m_sda;
            ev_stop  = m_scl_p & m_scl & ~m_sda_p & m_sda;
            to_ev = 0;
`ifdef EF_I2C_TIMEOUT_EN
            if (m_busy && !m_scl) begin
                if (lc < T) begin
                    lc++;
                    if (lc == T) to_ev = 1;
                end
            end else lc = 0;
`endif
            m_start = ev_start; m_stop = ev_stop; m_to = to_ev;
            if (ev_start) m_busy = 1;
            else if (ev_stop || to_ev) m_busy = 0;
            m_scl_p = m_scl; m_sda_p = m_sda;
            m_scl = filt_next(h_scl, m_scl);
            m_sda = filt_next(h_sda, m_sda);
            h_scl = {h_scl[14:0], scl_pad_i};
            h_sda = {h_sda[14:0], sda_pad_i};
        end
    end

    // Continuous compare plus pulse/level counters for the directed checks.
    int c_start = 0, c_stop = 0, c_to = 0, c_sda_low = 0;
    always @(negedge clk) begin
        if (started) begin
            chk("scl_i", scl_i, m_scl);
            chk("sda_i", sda_i, m_sda);
            chk("start_det", start_det, m_start);
            chk("stop_det", stop_det, m_stop);
            chk("bus_busy", bus_busy, m_busy);
            chk("scl_timeout", scl_timeout, m_to);
            chk("scl_pad_oen", scl_pad_oen_o, scl_oen_o | scl_o);
            chk("sda_pad_oen", sda_pad_oen_o, sda_oen_o | sda_o);
            if (start_det === 1'b1) c_start++;
            if (stop_det === 1'b1) c_stop++;
            if (scl_timeout === 1'b1) c_to++;
            if (sda_i === 1'b0) c_sda_low++;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr();
        c_start = 0; c_stop = 0; c_to = 0; c_sda_low = 0;
    endtask

    initial begin
        // Reset with pads high, controller released.
        tick(3);
        chk("rst_scl_i", scl_i, 1'b1);
        chk("rst_sda_i", sda_i, 1'b1);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_start", start_det, 1'b0);
        chk("rst_stop", stop_det, 1'b0);
        chk("rst_scl_oen", scl_pad_oen_o, 1'b1);
        chk("rst_sda_oen", sda_pad_oen_o, 1'b1);
        // Reset with pads low: filtered lines must still read high.
        scl_pad_i = 0; sda_pad_i = 0;
        tick(3);
        chk("rst_lo_scl_i", scl_i, 1'b1);
        chk("rst_lo_sda_i", sda_i, 1'b1);
        scl_pad_i = 1; sda_pad_i = 1;
        tick(1);
        rst = 0;
        tick(10);

        // 3-cycle SDA glitch is rejected.
        clr();
        sda_pad_i = 0; tick(3);
        sda_pad_i = 1; tick(10);
        chk_int("glitch_sda_low_cycles", c_sda_low, 0);
        chk_int("glitch_starts", c_start, 0);

        // 10-cycle SDA low with SCL high: filter latency, START then STOP.
        clr();
        sda_pad_i = 0;
        tick(5);  chk("fall_e5_sda_i", sda_i, 1'b1);
        tick(1);  chk("fall_e6_sda_i", sda_i, 1'b0);
                  chk("fall_e6_start", start_det, 1'b0);
        tick(1);  chk("start_e7_pulse", start_det, 1'b1);
                  chk("start_e7_busy", bus_busy, 1'b1);
        tick(1);  chk("start_e8_pulse", start_det, 1'b0);
        tick(2);
        sda_pad_i = 1;
        tick(5);  chk("rise_e5_sda_i", sda_i, 1'b0);
        tick(1);  chk("rise_e6_sda_i", sda_i, 1'b1);
        tick(1);  chk("stop_e7_pulse", stop_det, 1'b1);
                  chk("stop_e7_busy", bus_busy, 1'b0);
        tick(5);
        chk_int("start_count", c_start, 1);
        chk_int("stop_count", c_stop, 1);

        // SCL and SDA fall together, then SDA toggles under SCL low: no events.
        clr();
        scl_pad_i = 0; sda_pad_i = 0; tick(12);
        sda_pad_i = 1; tick(8);
        sda_pad_i = 0; tick(8);
        sda_pad_i = 1; tick(8);
        scl_pad_i = 1; tick(12);
        chk_int("same_edge_starts", c_start, 0);
        chk_int("scl_low_stops", c_stop, 0);
        chk("same_edge_busy", bus_busy, 1'b0);

        // Open-drain pad enables.
        scl_o = 1; scl_oen_o = 0; #1 chk("scl_oen_drive1", scl_pad_oen_o, 1'b1);
        scl_o = 0; scl_oen_o = 0; #1 chk("scl_oen_drive0", scl_pad_oen_o, 1'b0);
        scl_o = 0; scl_oen_o = 1; #1 chk("scl_oen_rel", scl_pad_oen_o, 1'b1);
        sda_o = 1; sda_oen_o = 0; #1 chk("sda_oen_drive1", sda_pad_oen_o, 1'b1);
        sda_o = 0; sda_oen_o = 0; #1 chk("sda_oen_drive0", sda_pad_oen_o, 1'b0);
        tick(2);
        sda_o = 0; sda_oen_o = 1; #1 chk("sda_oen_rel", sda_pad_oen_o, 1'b1);
        tick(2);

        // Mid-operation reset while busy.
        sda_pad_i = 0; tick(12);
        chk("midrst_pre_busy", bus_busy, 1'b1);
        rst = 1; sda_pad_i = 1; tick(1);
        chk("midrst_busy", bus_busy, 1'b0);
        chk("midrst_sda_i", sda_i, 1'b1);
        rst = 0; tick(12);
        chk("midrst_after_busy", bus_busy, 1'b0);

        // SCL held low while busy: timeout behaviour, then STOP seen in IDLE.
        clr();
        sda_pad_i = 0; tick(12);
        chk("to_start_busy", bus_busy, 1'b1);
        scl_pad_i = 0; tick(200);
`ifdef EF_I2C_TIMEOUT_EN
        chk_int("to_pulse_count", c_to, 1);
        chk("to_busy_after", bus_busy, 1'b0);
`else
        chk_int("to_pulse_count", c_to, 0);
        chk("to_busy_after", bus_busy, 1'b1);
`endif
        scl_pad_i = 1; tick(12);
        sda_pad_i = 1; tick(12);
        chk_int("to_stop_count", c_stop, 1);
        chk("to_final_busy", bus_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
